bus_mem_slave: RTL and testbench
================================

# bus_mem_slave

Parametrised, synthesizable memory slave for the MIPS CPU data bus. It replaces the fixed-constant read data the CPU bench used to drive with a real word-addressed RAM. It has configurable read and write wait states, a READY completion handshake and an error flag for out-of-range or misaligned accesses. It sits directly on the CPU's CS/WR_RD/ADDR/Data_BUS_* pins, both in simulation and in the FPGA top.

## Interface
- DATA_W, 32, data bus width in bits; multiple of 8, power of two
- ADDR_W, 32, address bus width
- DEPTH, 256, number of DATA_W words; power of two
- BASE_ADDR, 0, byte address of word 0
- WAIT_RD, 2, read wait states; must be ≥1 (elaboration error otherwise)
- WAIT_WR, 1, write wait states; ≥0
- DEFAULT_DATA, 32'h32323232, value returned for errored reads and driven after reset
- CLK  in  1  system clock; single clock domain. Reset is synchronous and active-high.
- rst  in  1  synchronous, active-high reset
- CS  in  1  request strobe; sampled only in IDLE
- WR_RD  in  1  1 = write, 0 = read; sampled with CS
- ADDR  in  ADDR_W  byte address; sampled with CS
- Data_BUS_WRITE  in  DATA_W  write data; sampled with CS
- Data_BUS_READ  out  DATA_W  read data, registered
- READY  out  1  one-cycle completion pulse
- ERR  out  1  qualifies READY; access was rejected

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE with CS=1:
  - Latch WR_RD, ADDR and data.
  - Compute index = (ADDR − BASE_ADDR) >> log2(DATA_W/8).
  - Compute err = (ADDR < BASE_ADDR) | (index ≥ DEPTH) | (ADDR low bits ≠ 0).
  - Load the wait counter with WAIT_RD or WAIT_WR.
  - Go to WAIT if the count is >0, else go to DONE.
- IDLE with CS=0: stay in IDLE.
- WAIT: decrement the counter; go to DONE when it reaches 1.
- DONE:
  - READY=1 and ERR=err.
  - Write with no error: RAM[index] ← latched data, committed in this cycle.
  - Read with no error: Data_BUS_READ ← RAM data.
  - Read with error: Data_BUS_READ ← DEFAULT_DATA.
  - Write with error: dropped, memory untouched.
  - Always return to IDLE.
- Latched request is authoritative. Changes to CS, ADDR or data after acceptance are ignored, including CS dropping mid-transaction.
- CS still high in the cycle after DONE: accepted as a new request (back-to-back). There is no CS-low requirement between transactions.
- Data_BUS_READ holds its value between reads; writes do not change it.
- Memory contents are not cleared by reset and are undefined at power-up.
- Reset in any state:
  - Next state is IDLE and the pending transaction is aborted.
  - An aborted write is never committed.
  - READY=0, ERR=0, Data_BUS_READ=DEFAULT_DATA.

## Timing
- Request accepted at rising edge N (IDLE, CS=1): READY is high in the cycle after edge N+W+1, where W is WAIT_RD or WAIT_WR.
- Read latency is WAIT_RD+1 cycles; write latency is WAIT_WR+1 cycles.
- Continuous back-to-back throughput: one transaction per W+2 cycles.
- RAM read is synchronous. The address is the latched index, presented from acceptance, and the RAM output is registered into Data_BUS_READ on entry to DONE. This is why WAIT_RD ≥1.
- READY and ERR are registered and never high for more than one consecutive cycle per transaction.
- All outputs settle within one cycle of rst being sampled high.

## Structure
- Shared package bus_mem_pkg holds:
  - state enum {IDLE, WAIT, DONE}
  - constants BUS_WR=1'b1 and BUS_RD=1'b0
  - function clog2 used for index shift and counter width
- Counter width is clog2(max(WAIT_RD, WAIT_WR)+1).
- One sub-module, bus_mem_ram: single-port synchronous RAM with DEPTH×DATA_W, write enable, and one-cycle registered read. It infers block RAM.
- The top level holds the FSM, address decode, error logic and output registers.

## Test plan
All scenarios use the defaults: DATA_W=32, DEPTH=256, BASE_ADDR=0, WAIT_RD=2, WAIT_WR=1, with the CPU-bus clock at 1.667 ns half-period.

1. **Reset.** Hold rst high for 3 cycles with CS toggling → READY=0, ERR=0, Data_BUS_READ=32'h32323232 throughout. No access is accepted.
2. **Write then read.**
   - Write 32'hDEADBEEF to 0x10, accepted at edge N → READY at N+2 with ERR=0.
   - Read 0x10 accepted at edge M → READY at M+3, Data_BUS_READ=32'hDEADBEEF, held after READY falls.
3. **Out of range.**
   - Read 0x400 → READY with ERR=1, data 32'h32323232.
   - Write 32'h12345678 to 0x400, then read 0x0 → returns the prior contents of word 0.
4. **Misaligned.** Write 0x11 → READY with ERR=1; word 4 (0x10) is unchanged.
5. **Reset mid-write.**
   - Write 32'hCAFEF00D to 0x20; assert rst in the WAIT cycle → no READY.
   - Read 0x20 after reset → returns the previously written 32'h0BADC0DE.
6. **Back-to-back reads.** CS held high with reads of 0x0, 0x4, 0x8 → READY pulses exactly 4 cycles apart, each returning its own word.

Source files
------------

// File: rtl/bus_mem_pkg.sv
// Shared types and helpers for the CPU data-bus memory slave.
`timescale 1ns/1ps
package bus_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  localparam logic BUS_WR = 1'b1;
  localparam logic BUS_RD = 1'b0;

  // Ceiling log2; clog2(1) is 0.
  function automatic int clog2(input int unsigned value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bus_mem_ram.sv
// Single-port synchronous RAM, write-enable plus one-cycle registered read.
`timescale 1ns/1ps
module bus_mem_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int AW     = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array has no reset branch; resetting it would block RAM inference and its contents are defined only by writes.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/bus_mem_slave.sv
// Word-addressed RAM slave for the CPU data bus: wait states, READY pulse,
// and ERR for out-of-range or misaligned accesses.
`timescale 1ns/1ps
module bus_mem_slave
  import bus_mem_pkg::*;
#(
  parameter int                DATA_W       = 32,
  parameter int                ADDR_W       = 32,
  parameter int                DEPTH        = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
  parameter int                WAIT_RD      = 2,
  parameter int                WAIT_WR      = 1,
  parameter logic [DATA_W-1:0] DEFAULT_DATA = DATA_W'(32'h3232_3232)
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              CS,
  input  logic              WR_RD,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] Data_BUS_WRITE,
  output logic [DATA_W-1:0] Data_BUS_READ,
  output logic              READY,
  output logic              ERR
);

  localparam int BYTE_SHIFT = clog2(DATA_W / 8);
  localparam int IDX_W      = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam int WAIT_MAX   = (WAIT_RD > WAIT_WR) ? WAIT_RD : WAIT_WR;
  localparam int CNT_W      = clog2(WAIT_MAX + 1);

  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((64'd1 << BYTE_SHIFT) - 64'd1);
  localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_RD   = CNT_W'(WAIT_RD);
  localparam logic [CNT_W-1:0]  CNT_WR   = CNT_W'(WAIT_WR);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  // The read path needs one cycle for the synchronous RAM before DONE.
  if (WAIT_RD < 1) begin : g_bad_wait_rd
    $error("bus_mem_slave: WAIT_RD must be at least 1");
  end

  state_t            state;
  logic [CNT_W-1:0]  cnt_q;
  logic              wr_q;
  logic              err_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] data_q;

  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] word_idx;
  logic              req_err;
  logic [CNT_W-1:0]  load_cnt;

  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;

  // NOTE: every signal here is assigned on every path, so no latch can be inferred.
  always_comb begin
    offset   = ADDR - BASE_ADDR;
    word_idx = offset >> BYTE_SHIFT;
    req_err  = (ADDR < BASE_ADDR) || (word_idx >= DEPTH_A) || ((ADDR & LOW_MASK) != '0);
    load_cnt = (WR_RD == BUS_WR) ? CNT_WR : CNT_RD;
  end

  // A reset sampled in the DONE cycle must also stop the commit.
  assign ram_we = (state == DONE) && (wr_q == BUS_WR) && !err_q && !rst;

  bus_mem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (IDX_W)
  ) u_ram (
    .clk   (CLK),
    .we    (ram_we),
    .addr  (idx_q),
    .wdata (data_q),
    .rdata (ram_rdata)
  );

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state         <= IDLE;
      cnt_q         <= '0;
      READY         <= 1'b0;
      ERR           <= 1'b0;
      Data_BUS_READ <= DEFAULT_DATA;
    end else begin
      READY <= 1'b0;
      ERR   <= 1'b0;
      case (state)
        IDLE: begin
          if (CS) begin
            wr_q   <= WR_RD;
            err_q  <= req_err;
            idx_q  <= word_idx[IDX_W-1:0];
            data_q <= Data_BUS_WRITE;
            cnt_q  <= load_cnt;
            state  <= (load_cnt != '0) ? WAIT : DONE;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state <= DONE;
        end
        DONE: begin
          READY <= 1'b1;
          ERR   <= err_q;
          if (wr_q == BUS_RD) Data_BUS_READ <= err_q ? DEFAULT_DATA : ram_rdata;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_mem_slave.sv
// Directed bench for bus_mem_slave with a transaction-level model checked every cycle.
`timescale 1ns/1ps
module tb_bus_mem_slave;

  localparam int          WAIT_RD = 2;
  localparam int          WAIT_WR = 1;
  localparam int          DEPTH   = 256;
  localparam logic [31:0] DEF     = 32'h3232_3232;

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic        CS = 1'b0;
  logic        WR_RD = 1'b0;
  logic [31:0] ADDR = '0;
  logic [31:0] Data_BUS_WRITE = '0;
  logic [31:0] Data_BUS_READ;
  logic        READY;
  logic        ERR;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always #1.667 CLK = ~CLK;

  bus_mem_slave #(
    .DATA_W       (32),
    .ADDR_W       (32),
    .DEPTH        (DEPTH),
    .BASE_ADDR    (32'h0),
    .WAIT_RD      (WAIT_RD),
    .WAIT_WR      (WAIT_WR),
    .DEFAULT_DATA (DEF)
  ) dut (
    .CLK            (CLK),
    .rst            (rst),
    .CS             (CS),
    .WR_RD          (WR_RD),
    .ADDR           (ADDR),
    .Data_BUS_WRITE (Data_BUS_WRITE),
    .Data_BUS_READ  (Data_BUS_READ),
    .READY          (READY),
    .ERR            (ERR)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model: one request in flight, finishing W+1 edges after
  // acceptance; the slave is free again the edge after completion.
  bit [31:0]   m_mem [DEPTH];
  bit          m_known [DEPTH];
  bit          p_valid;
  bit          p_wr;
  bit          p_err;
  int          p_idx;
  int          p_done;
  logic [31:0] p_data;
  logic        exp_ready;
  logic        exp_err;
  logic [31:0] exp_data;
  bit          exp_known;

  function automatic bit addr_bad(input logic [31:0] a);
    longint unsigned x;
    x = 64'(a);
    return (x % 4 != 0) || (x / 4 >= DEPTH);
  endfunction

  initial begin : model_and_compare
    p_valid   = 1'b0;
    exp_ready = 1'b0;
    exp_err   = 1'b0;
    exp_data  = DEF;
    exp_known = 1'b1;
    forever begin
      @(posedge CLK);
      cyc++;
      if (rst) begin
        p_valid   = 1'b0;
        exp_ready = 1'b0;
        exp_err   = 1'b0;
        exp_data  = DEF;
        exp_known = 1'b1;
      end else begin
        exp_ready = 1'b0;
        exp_err   = 1'b0;
        if (p_valid) begin
          if (cyc == p_done) begin
            p_valid   = 1'b0;
            exp_ready = 1'b1;
            exp_err   = p_err;
            if (p_wr && !p_err) begin
              m_mem[p_idx]   = p_data;
              m_known[p_idx] = 1'b1;
            end else if (!p_wr) begin
              exp_data  = p_err ? DEF : m_mem[p_idx];
              exp_known = p_err ? 1'b1 : m_known[p_idx];
            end
          end
        end else if (CS) begin
          p_valid = 1'b1;
          p_wr    = WR_RD;
          p_err   = addr_bad(ADDR);
          p_idx   = p_err ? 0 : int'(ADDR >> 2);
          p_data  = Data_BUS_WRITE;
          p_done  = cyc + (WR_RD ? WAIT_WR : WAIT_RD) + 1;
        end
      end
      @(negedge CLK);
      check_bit("ready", READY, exp_ready);
      check_bit("err", ERR, exp_err);
      if (exp_known) check("rdata", Data_BUS_READ, exp_data);
    end
  end

  // One request; inputs are scrambled right after acceptance.
  task automatic xact(input logic wr, input logic [31:0] a, input logic [31:0] d,
                      output int lat, output logic err, output logic [31:0] rdata);
    int acc;
    bit seen;
    @(negedge CLK);
    CS = 1'b1; WR_RD = wr; ADDR = a; Data_BUS_WRITE = d;
    @(negedge CLK);
    acc = cyc;
    CS = 1'b0; WR_RD = ~wr; ADDR = a ^ 32'h4; Data_BUS_WRITE = ~d;
    lat = -1; err = 1'b0; rdata = '0; seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (READY) begin
        seen = 1'b1; lat = cyc - acc; err = ERR; rdata = Data_BUS_READ;
        break;
      end
      @(negedge CLK);
    end
    if (!seen) check_bit("xact_timeout", 1'b0, 1'b1);
  endtask

  task automatic wr_ok(input logic [31:0] a, input logic [31:0] d, input string name);
    int lat; logic e; logic [31:0] r;
    xact(1'b1, a, d, lat, e, r);
    check({name, "_lat"}, 32'(lat), 32'd2);
    check_bit({name, "_err"}, e, 1'b0);
  endtask

  task automatic rd_expect(input logic [31:0] a, input logic [31:0] d, input logic exp_e,
                           input string name);
    int lat; logic e; logic [31:0] r;
    xact(1'b0, a, 32'h0, lat, e, r);
    check({name, "_lat"}, 32'(lat), 32'd3);
    check_bit({name, "_err"}, e, exp_e);
    check({name, "_data"}, r, d);
  endtask

  initial begin : stimulus
    int lat; logic e; logic [31:0] r;
    int n_ready; bit seen;
    int rc [3];
    logic [31:0] b_addr [3];
    logic [31:0] b_data [3];

    // Reset held three cycles while CS toggles.
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      CS = ~CS; WR_RD = i[0]; ADDR = 32'h10;
      check_bit("rst_ready", READY, 1'b0);
      check_bit("rst_err", ERR, 1'b0);
      check("rst_data", Data_BUS_READ, DEF);
    end
    @(negedge CLK);
    rst = 1'b0; CS = 1'b0;
    n_ready = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      if (READY) n_ready++;
    end
    check("rst_no_accept", 32'(n_ready), 32'd0);

    // Known background contents.
    wr_ok(32'h0,   32'hA5A5_0000, "pre_w0");
    wr_ok(32'h4,   32'h1111_0004, "pre_w1");
    wr_ok(32'h8,   32'h2222_0008, "pre_w2");
    wr_ok(32'h20,  32'h0BAD_C0DE, "pre_w8");
    wr_ok(32'h24,  32'h1111_2222, "pre_w9");
    wr_ok(32'h3FC, 32'h7777_3FC0, "top_w");

    // Write then read; data held after READY drops.
    wr_ok(32'h10, 32'hDEAD_BEEF, "wr10");
    rd_expect(32'h10, 32'hDEAD_BEEF, 1'b0, "rd10");
    @(negedge CLK);
    @(negedge CLK);
    check_bit("hold_ready", READY, 1'b0);
    check("hold_data", Data_BUS_READ, 32'hDEAD_BEEF);
    rd_expect(32'h3FC, 32'h7777_3FC0, 1'b0, "rd_top");

    // Out of range.
    rd_expect(32'h400, DEF, 1'b1, "rd_oor");
    xact(1'b1, 32'h400, 32'h1234_5678, lat, e, r);
    check("wr_oor_lat", 32'(lat), 32'd2);
    check_bit("wr_oor_err", e, 1'b1);
    rd_expect(32'h0, 32'hA5A5_0000, 1'b0, "rd_w0");

    // Misaligned.
    xact(1'b1, 32'h11, 32'hFFFF_FFFF, lat, e, r);
    check_bit("wr_mis_err", e, 1'b1);
    rd_expect(32'h10, 32'hDEAD_BEEF, 1'b0, "rd_after_mis");
    rd_expect(32'h13, DEF, 1'b1, "rd_mis");

    // Reset in the WAIT cycle of a write.
    @(negedge CLK);
    CS = 1'b1; WR_RD = 1'b1; ADDR = 32'h20; Data_BUS_WRITE = 32'hCAFE_F00D;
    @(negedge CLK);
    CS = 1'b0; rst = 1'b1;
    @(negedge CLK);
    rst = 1'b0;
    n_ready = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      if (READY) n_ready++;
    end
    check("abort_wait_ready", 32'(n_ready), 32'd0);
    rd_expect(32'h20, 32'h0BAD_C0DE, 1'b0, "rd_abort_wait");

    // Reset in the DONE cycle of a write.
    @(negedge CLK);
    CS = 1'b1; WR_RD = 1'b1; ADDR = 32'h24; Data_BUS_WRITE = 32'hCAFE_F00D;
    @(negedge CLK);
    CS = 1'b0;
    @(negedge CLK);
    rst = 1'b1;
    @(negedge CLK);
    rst = 1'b0;
    check_bit("abort_done_ready", READY, 1'b0);
    rd_expect(32'h24, 32'h1111_2222, 1'b0, "rd_abort_done");

    // Back-to-back reads with CS held high.
    b_addr[0] = 32'h0;         b_addr[1] = 32'h4;         b_addr[2] = 32'h8;
    b_data[0] = 32'hA5A5_0000; b_data[1] = 32'h1111_0004; b_data[2] = 32'h2222_0008;
    @(negedge CLK);
    CS = 1'b1; WR_RD = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ADDR = b_addr[k];
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge CLK);
        if (READY) begin
          seen = 1'b1;
          break;
        end
      end
      if (!seen) check_bit("b2b_timeout", 1'b0, 1'b1);
      rc[k] = cyc;
      check("b2b_data", Data_BUS_READ, b_data[k]);
      if (k == 2) CS = 1'b0;
    end
    check("b2b_gap01", 32'(rc[1] - rc[0]), 32'd4);
    check("b2b_gap12", 32'(rc[2] - rc[1]), 32'd4);

    repeat (4) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: run did not complete by cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
